// File: rtl/ace_trs_pkg.sv
// Shared types and encodings for the ACE transaction classifier.
// Holds the decode-mode and class enums, the snoop and domain encodings used by
// the decoders, and default AW/AR channel structs. Any channel struct with the
// snoop/bar/domain fields can be used instead.
package ace_trs_pkg;

  typedef enum logic [1:0] {
    DEC_FULL       = 2'd0,
    DEC_ALL_SNOOP  = 2'd1,
    DEC_ALL_BYPASS = 2'd2
  } decode_mode_e;

  typedef enum logic {
    TRS_BYPASS = 1'b0,
    TRS_SNOOP  = 1'b1
  } trs_class_e;

  localparam logic [2:0] AW_WRITE_BACK     = 3'b011;
  localparam logic [2:0] AW_WRITE_NO_SNOOP = 3'b000;
  localparam logic [3:0] AR_READ_NO_SNOOP  = 4'b0000;

  localparam logic [1:0] DOM_NSH = 2'b00;
  localparam logic [1:0] DOM_ISH = 2'b01;
  localparam logic [1:0] DOM_OSH = 2'b10;
  localparam logic [1:0] DOM_SYS = 2'b11;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  snoop;
    logic [1:0]  bar;
    logic [1:0]  domain;
  } ace_aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [1:0]  bar;
    logic [1:0]  domain;
  } ace_ar_chan_t;

endpackage

// File: rtl/ace_trs_classifier_chan.sv
// Per-channel classifier: decode at acceptance, 2-entry FIFO carrying the class
// bit, outstanding-snoop limiter and optional performance counters.
// Ports: valid_i/ready_o/chan_i upstream; valid_o/ready_i/chan_o/snoop_o
// downstream; done_i retires one snoop-class transaction; snoop_cnt_o and
// bypass_cnt_o count output handshakes per class (zero unless
// ACE_TRS_CLASSIFIER_PERF_EN is defined).
module ace_trs_chan_dec
  import ace_trs_pkg::*;
#(
  parameter type          chan_t      = ace_aw_chan_t,
  parameter bit           IsWrite     = 1'b1,
  parameter decode_mode_e Mode        = DEC_FULL,
  parameter int unsigned  MaxSnoopTrs = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  chan_t       chan_i,
  output logic        valid_o,
  input  logic        ready_i,
  output chan_t       chan_o,
  output logic        snoop_o,
  input  logic        done_i,
  output logic [31:0] snoop_cnt_o,
  output logic [31:0] bypass_cnt_o
);

  localparam int unsigned    CntW   = $clog2(MaxSnoopTrs + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxSnoopTrs);

  trs_class_e full_cls, in_cls;

  // Field widths differ between AW and AR, so each decoder lives in its own branch.
  if (IsWrite) begin : g_aw_dec
    logic wb, wns;
    assign wb  = (chan_i.snoop == AW_WRITE_BACK) && !chan_i.bar[0] &&
                 (chan_i.domain != DOM_SYS);
    assign wns = (chan_i.snoop == AW_WRITE_NO_SNOOP) && !chan_i.bar[0] &&
                 ((chan_i.domain == DOM_NSH) || (chan_i.domain == DOM_SYS));
    assign full_cls = (wb || wns) ? TRS_BYPASS : TRS_SNOOP;
  end else begin : g_ar_dec
    logic rns;
    assign rns = (chan_i.snoop == AR_READ_NO_SNOOP) && !chan_i.bar[0] &&
                 ((chan_i.domain == DOM_NSH) || (chan_i.domain == DOM_SYS));
    assign full_cls = rns ? TRS_BYPASS : TRS_SNOOP;
  end

  assign in_cls = (Mode == DEC_ALL_SNOOP)  ? TRS_SNOOP  :
                  (Mode == DEC_ALL_BYPASS) ? TRS_BYPASS : full_cls;

  chan_t           mem_q [2];
  trs_class_e      cls_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      fill_q, fill_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push, pop, head_snoop, stall, inc, dec;

  assign head_snoop = (cls_q[rd_ptr_q] == TRS_SNOOP);
  // Stall looks only at registered cnt, so valid_o cannot drop before a handshake.
  assign stall      = head_snoop && (cnt_q == CntMax);
  assign ready_o    = (fill_q != 2'd2);
  assign valid_o    = (fill_q != 2'd0) && !stall;
  assign chan_o     = mem_q[rd_ptr_q];
  assign snoop_o    = head_snoop;
  assign push       = valid_i && ready_o;
  assign pop        = valid_o && ready_i;
  assign inc        = pop && head_snoop;
  assign dec        = done_i && (cnt_q != '0);

  always_comb begin
    fill_d = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + 2'd1;
    end else if (pop && !push) begin
      fill_d = fill_q - 2'd1;
    end
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      cls_q[0] <= TRS_BYPASS;
      cls_q[1] <= TRS_BYPASS;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= chan_i;
        cls_q[wr_ptr_q] <= in_cls;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  done_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(done_i && (cnt_q == '0)));
`endif

`ifdef ACE_TRS_CLASSIFIER_PERF_EN
  logic [31:0] snoop_cnt_q, bypass_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snoop_cnt_q  <= '0;
      bypass_cnt_q <= '0;
    end else begin
      if (pop && head_snoop && (snoop_cnt_q != '1)) begin
        snoop_cnt_q <= snoop_cnt_q + 32'd1;
      end
      if (pop && !head_snoop && (bypass_cnt_q != '1)) begin
        bypass_cnt_q <= bypass_cnt_q + 32'd1;
      end
    end
  end

  assign snoop_cnt_o  = snoop_cnt_q;
  assign bypass_cnt_o = bypass_cnt_q;
`else
  assign snoop_cnt_o  = '0;
  assign bypass_cnt_o = '0;
`endif

endmodule

// File: rtl/ace_trs_classifier.sv
// ACE transaction classifier for the AW and AR channels of one slave port.
// Each channel decodes requests into bypass/snoop class, buffers them in a
// 2-entry skid FIFO and forwards them with a route flag (snoop_o: 1 = CCU,
// 0 = memory). A per-channel limiter holds snoop-class heads once MaxSnoopTrs
// are outstanding; done_i retires one. AW and AR are independent.
// Ports: aw_*/ar_* upstream (valid_i/ready_o/chan_i), downstream
// (valid_o/ready_i/chan_o/snoop_o), done_i retire pulse, *_cnt_o 32-bit
// performance counters.
// Macro ACE_TRS_CLASSIFIER_PERF_EN enables the counters; otherwise they read 0.
module ace_trs_classifier
  import ace_trs_pkg::*;
#(
  parameter type          aw_chan_t   = ace_aw_chan_t,
  parameter type          ar_chan_t   = ace_ar_chan_t,
  parameter decode_mode_e AwMode      = DEC_FULL,
  parameter decode_mode_e ArMode      = DEC_FULL,
  parameter int unsigned  MaxSnoopTrs = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        aw_valid_i,
  output logic        aw_ready_o,
  input  aw_chan_t    aw_chan_i,
  output logic        aw_valid_o,
  input  logic        aw_ready_i,
  output aw_chan_t    aw_chan_o,
  output logic        aw_snoop_o,
  input  logic        aw_done_i,
  input  logic        ar_valid_i,
  output logic        ar_ready_o,
  input  ar_chan_t    ar_chan_i,
  output logic        ar_valid_o,
  input  logic        ar_ready_i,
  output ar_chan_t    ar_chan_o,
  output logic        ar_snoop_o,
  input  logic        ar_done_i,
  output logic [31:0] aw_snoop_cnt_o,
  output logic [31:0] ar_snoop_cnt_o,
  output logic [31:0] aw_bypass_cnt_o,
  output logic [31:0] ar_bypass_cnt_o
);

  ace_trs_chan_dec #(
    .chan_t      (aw_chan_t),
    .IsWrite     (1'b1),
    .Mode        (AwMode),
    .MaxSnoopTrs (MaxSnoopTrs)
  ) u_aw (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (aw_valid_i),
    .ready_o      (aw_ready_o),
    .chan_i       (aw_chan_i),
    .valid_o      (aw_valid_o),
    .ready_i      (aw_ready_i),
    .chan_o       (aw_chan_o),
    .snoop_o      (aw_snoop_o),
    .done_i       (aw_done_i),
    .snoop_cnt_o  (aw_snoop_cnt_o),
    .bypass_cnt_o (aw_bypass_cnt_o)
  );

  ace_trs_chan_dec #(
    .chan_t      (ar_chan_t),
    .IsWrite     (1'b0),
    .Mode        (ArMode),
    .MaxSnoopTrs (MaxSnoopTrs)
  ) u_ar (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (ar_valid_i),
    .ready_o      (ar_ready_o),
    .chan_i       (ar_chan_i),
    .valid_o      (ar_valid_o),
    .ready_i      (ar_ready_i),
    .chan_o       (ar_chan_o),
    .snoop_o      (ar_snoop_o),
    .done_i       (ar_done_i),
    .snoop_cnt_o  (ar_snoop_cnt_o),
    .bypass_cnt_o (ar_bypass_cnt_o)
  );

endmodule

// File: tb/tb_ace_trs_classifier.sv
module tb_ace_trs_classifier;
  import ace_trs_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // dut_a: full decode, MaxSnoopTrs = 2
  logic a_aw_valid_i = 0, a_aw_ready_o, a_aw_valid_o, a_aw_ready_i = 1, a_aw_snoop_o;
  logic a_aw_done_i = 0;
  ace_aw_chan_t a_aw_chan_i = '0, a_aw_chan_o;
  logic a_ar_valid_i = 0, a_ar_ready_o, a_ar_valid_o, a_ar_ready_i = 1, a_ar_snoop_o;
  logic a_ar_done_i = 0;
  ace_ar_chan_t a_ar_chan_i = '0, a_ar_chan_o;
  logic [31:0] a_aw_scnt, a_ar_scnt, a_aw_bcnt, a_ar_bcnt;

  // dut_b: forced modes
  logic b_aw_valid_i = 0, b_aw_ready_o, b_aw_valid_o, b_aw_snoop_o;
  logic b_ar_valid_i = 0, b_ar_ready_o, b_ar_valid_o, b_ar_snoop_o;
  logic b_ready = 1, b_done = 0;
  ace_aw_chan_t b_aw_chan_i = '0, b_aw_chan_o;
  ace_ar_chan_t b_ar_chan_i = '0, b_ar_chan_o;
  logic [31:0] b_aw_scnt, b_ar_scnt, b_aw_bcnt, b_ar_bcnt;

  ace_trs_classifier #(
    .AwMode(DEC_FULL), .ArMode(DEC_FULL), .MaxSnoopTrs(2)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(a_aw_valid_i), .aw_ready_o(a_aw_ready_o), .aw_chan_i(a_aw_chan_i),
    .aw_valid_o(a_aw_valid_o), .aw_ready_i(a_aw_ready_i), .aw_chan_o(a_aw_chan_o),
    .aw_snoop_o(a_aw_snoop_o), .aw_done_i(a_aw_done_i),
    .ar_valid_i(a_ar_valid_i), .ar_ready_o(a_ar_ready_o), .ar_chan_i(a_ar_chan_i),
    .ar_valid_o(a_ar_valid_o), .ar_ready_i(a_ar_ready_i), .ar_chan_o(a_ar_chan_o),
    .ar_snoop_o(a_ar_snoop_o), .ar_done_i(a_ar_done_i),
    .aw_snoop_cnt_o(a_aw_scnt), .ar_snoop_cnt_o(a_ar_scnt),
    .aw_bypass_cnt_o(a_aw_bcnt), .ar_bypass_cnt_o(a_ar_bcnt)
  );

  ace_trs_classifier #(
    .AwMode(DEC_ALL_BYPASS), .ArMode(DEC_ALL_SNOOP), .MaxSnoopTrs(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(b_aw_valid_i), .aw_ready_o(b_aw_ready_o), .aw_chan_i(b_aw_chan_i),
    .aw_valid_o(b_aw_valid_o), .aw_ready_i(b_ready), .aw_chan_o(b_aw_chan_o),
    .aw_snoop_o(b_aw_snoop_o), .aw_done_i(b_done),
    .ar_valid_i(b_ar_valid_i), .ar_ready_o(b_ar_ready_o), .ar_chan_i(b_ar_chan_i),
    .ar_valid_o(b_ar_valid_o), .ar_ready_i(b_ready), .ar_chan_o(b_ar_chan_o),
    .ar_snoop_o(b_ar_snoop_o), .ar_done_i(b_done),
    .aw_snoop_cnt_o(b_aw_scnt), .ar_snoop_cnt_o(b_ar_scnt),
    .aw_bypass_cnt_o(b_aw_bcnt), .ar_bypass_cnt_o(b_ar_bcnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference classification, written straight from the ACE encodings.
  function automatic logic aw_is_snoop(input ace_aw_chan_t c);
    if (c.bar[0]) return 1'b1;
    if (c.snoop == 3'b011 && c.domain != 2'b11) return 1'b0;
    if (c.snoop == 3'b000 && (c.domain == 2'b00 || c.domain == 2'b11)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic ar_is_snoop(input ace_ar_chan_t c);
    if (c.bar[0]) return 1'b1;
    if (c.snoop == 4'b0000 && (c.domain == 2'b00 || c.domain == 2'b11)) return 1'b0;
    return 1'b1;
  endfunction

  // Scoreboard for dut_a: push on input handshake, pop on output handshake.
  ace_aw_chan_t aw_exp_q[$];
  logic         aw_cls_q[$];
  ace_ar_chan_t ar_exp_q[$];
  logic         ar_cls_q[$];
  ace_aw_chan_t aw_e;
  ace_ar_chan_t ar_e;
  logic         cls_e;
  int aw_snp_n = 0, aw_byp_n = 0, ar_snp_n = 0, ar_byp_n = 0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      aw_exp_q.delete(); aw_cls_q.delete(); ar_exp_q.delete(); ar_cls_q.delete();
      aw_snp_n = 0; aw_byp_n = 0; ar_snp_n = 0; ar_byp_n = 0;
    end else begin
      if (a_aw_valid_i && a_aw_ready_o) begin
        aw_exp_q.push_back(a_aw_chan_i);
        aw_cls_q.push_back(aw_is_snoop(a_aw_chan_i));
      end
      if (a_ar_valid_i && a_ar_ready_o) begin
        ar_exp_q.push_back(a_ar_chan_i);
        ar_cls_q.push_back(ar_is_snoop(a_ar_chan_i));
      end
      if (a_aw_valid_o && a_aw_ready_i) begin
        if (aw_exp_q.size() == 0) begin
          check("aw_sb_unexpected", 64'd1, 64'd0);
        end else begin
          aw_e = aw_exp_q.pop_front();
          cls_e = aw_cls_q.pop_front();
          check("aw_sb_chan", 64'(a_aw_chan_o), 64'(aw_e));
          check("aw_sb_snoop", 64'(a_aw_snoop_o), 64'(cls_e));
          if (cls_e) aw_snp_n++; else aw_byp_n++;
        end
      end
      if (a_ar_valid_o && a_ar_ready_i) begin
        if (ar_exp_q.size() == 0) begin
          check("ar_sb_unexpected", 64'd1, 64'd0);
        end else begin
          ar_e = ar_exp_q.pop_front();
          cls_e = ar_cls_q.pop_front();
          check("ar_sb_chan", 64'(a_ar_chan_o), 64'(ar_e));
          check("ar_sb_snoop", 64'(a_ar_snoop_o), 64'(cls_e));
          if (cls_e) ar_snp_n++; else ar_byp_n++;
        end
      end
    end
  end

  // Drive one request and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_aw(input ace_aw_chan_t c);
    bit ok = 0;
    a_aw_chan_i = c;
    a_aw_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_aw_ready_o) begin ok = 1; break; end
    end
    if (!ok) check("aw_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    a_aw_valid_i = 1'b0;
  endtask

  task automatic send_ar(input ace_ar_chan_t c);
    bit ok = 0;
    a_ar_chan_i = c;
    a_ar_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_ar_ready_o) begin ok = 1; break; end
    end
    if (!ok) check("ar_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    a_ar_valid_i = 1'b0;
  endtask

  function automatic ace_aw_chan_t mk_aw(input logic [31:0] addr, input logic [2:0] sn,
                                         input logic [1:0] bar, input logic [1:0] dom);
    ace_aw_chan_t c;
    c.id = addr[3:0]; c.addr = addr; c.snoop = sn; c.bar = bar; c.domain = dom;
    return c;
  endfunction

  function automatic ace_ar_chan_t mk_ar(input logic [31:0] addr, input logic [3:0] sn,
                                         input logic [1:0] bar, input logic [1:0] dom);
    ace_ar_chan_t c;
    c.id = addr[3:0]; c.addr = addr; c.snoop = sn; c.bar = bar; c.domain = dom;
    return c;
  endfunction

  typedef struct {
    logic       is_ar;
    logic [3:0] snoop;
    logic [1:0] bar;
    logic [1:0] domain;
    logic       exp_snoop;
  } vec_t;

  vec_t vecs[12];

  initial begin
    ace_aw_chan_t c0, c1, c2;
    bit drained;
    int unsigned exp_aw_s, exp_aw_b, exp_ar_s, exp_ar_b;

    vecs[0]  = '{1'b0, 4'b0011, 2'b00, 2'b10, 1'b0};
    vecs[1]  = '{1'b0, 4'b0011, 2'b00, 2'b11, 1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 2'b00, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 2'b00, 2'b01, 1'b1};
    vecs[4]  = '{1'b0, 4'b0011, 2'b01, 2'b00, 1'b1};
    vecs[5]  = '{1'b0, 4'b0010, 2'b00, 2'b00, 1'b1};
    vecs[6]  = '{1'b0, 4'b0000, 2'b10, 2'b11, 1'b0};
    vecs[7]  = '{1'b1, 4'b0000, 2'b00, 2'b01, 1'b1};
    vecs[8]  = '{1'b1, 4'b0000, 2'b00, 2'b11, 1'b0};
    vecs[9]  = '{1'b1, 4'b0000, 2'b00, 2'b00, 1'b0};
    vecs[10] = '{1'b1, 4'b0000, 2'b01, 2'b00, 1'b1};
    vecs[11] = '{1'b1, 4'b0001, 2'b00, 2'b00, 1'b1};

    // Reset state
    #12;
    check("rst_aw_ready", 64'(a_aw_ready_o), 64'd1);
    check("rst_aw_valid", 64'(a_aw_valid_o), 64'd0);
    check("rst_aw_snoop", 64'(a_aw_snoop_o), 64'd0);
    check("rst_aw_chan", 64'(a_aw_chan_o), 64'd0);
    check("rst_ar_ready", 64'(a_ar_ready_o), 64'd1);
    check("rst_ar_valid", 64'(a_ar_valid_o), 64'd0);
    check("rst_aw_scnt", 64'(a_aw_scnt), 64'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Table of single transactions: latency, class, limiter count
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_ar)
        send_ar(mk_ar(32'h1000 + i, vecs[i].snoop, vecs[i].bar, vecs[i].domain));
      else
        send_aw(mk_aw(32'h1000 + i, vecs[i].snoop[2:0], vecs[i].bar, vecs[i].domain));
      @(negedge clk);
      if (vecs[i].is_ar) begin
        check($sformatf("vec%0d_valid", i), 64'(a_ar_valid_o), 64'd1);
        check($sformatf("vec%0d_snoop", i), 64'(a_ar_snoop_o), 64'(vecs[i].exp_snoop));
      end else begin
        check($sformatf("vec%0d_valid", i), 64'(a_aw_valid_o), 64'd1);
        check($sformatf("vec%0d_snoop", i), 64'(a_aw_snoop_o), 64'(vecs[i].exp_snoop));
      end
      @(posedge clk); #1;
      if (vecs[i].is_ar)
        check($sformatf("vec%0d_cnt", i), 64'(dut_a.u_ar.cnt_q), 64'(vecs[i].exp_snoop));
      else
        check($sformatf("vec%0d_cnt", i), 64'(dut_a.u_aw.cnt_q), 64'(vecs[i].exp_snoop));
      if (vecs[i].exp_snoop) begin
        if (vecs[i].is_ar) a_ar_done_i = 1'b1; else a_aw_done_i = 1'b1;
        @(posedge clk); #1;
        a_ar_done_i = 1'b0; a_aw_done_i = 1'b0;
      end
    end

    // Limiter: three snoop ARs with MaxSnoopTrs = 2
    send_ar(mk_ar(32'h2000, 4'b0000, 2'b00, 2'b01));
    send_ar(mk_ar(32'h2001, 4'b0000, 2'b00, 2'b01));
    send_ar(mk_ar(32'h2002, 4'b0000, 2'b00, 2'b01));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid_low", 64'(a_ar_valid_o), 64'd0);
    end
    check("stall_ready", 64'(a_ar_ready_o), 64'd1);
    check("stall_cnt", 64'(dut_a.u_ar.cnt_q), 64'd2);
    @(posedge clk); #1;
    a_ar_done_i = 1'b1;
    @(negedge clk);
    check("release_same_cycle", 64'(a_ar_valid_o), 64'd0);
    @(posedge clk); #1;
    a_ar_done_i = 1'b0;
    @(negedge clk);
    check("release_next_valid", 64'(a_ar_valid_o), 64'd1);
    check("release_next_addr", 64'(a_ar_chan_o.addr), 64'h2002);
    @(posedge clk); #1;
    a_ar_done_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_ar_done_i = 1'b0;
    check("drain_cnt", 64'(dut_a.u_ar.cnt_q), 64'd0);

    // Backpressure: three back-to-back bypass AWs with ready_i low
    c0 = mk_aw(32'h3000, 3'b011, 2'b00, 2'b00);
    c1 = mk_aw(32'h3001, 3'b011, 2'b00, 2'b01);
    c2 = mk_aw(32'h3002, 3'b000, 2'b00, 2'b11);
    a_aw_ready_i = 1'b0;
    send_aw(c0);
    send_aw(c1);
    a_aw_chan_i = c2;
    a_aw_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(a_aw_ready_o), 64'd0);
      check("bp_valid_held", 64'(a_aw_valid_o), 64'd1);
      check("bp_chan_stable", 64'(a_aw_chan_o), 64'(c0));
    end
    @(posedge clk); #1;
    a_aw_ready_i = 1'b1;
    drained = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_aw_valid_i && a_aw_ready_o) begin
        @(posedge clk); #1;
        a_aw_valid_i = 1'b0;
      end
      if (!a_aw_valid_i && aw_exp_q.size() == 0) begin drained = 1; break; end
    end
    check("bp_drained", 64'(drained), 64'd1);

    // Performance counters against scoreboard handshake counts
    @(posedge clk); #1;
`ifdef ACE_TRS_CLASSIFIER_PERF_EN
    exp_aw_s = aw_snp_n; exp_aw_b = aw_byp_n; exp_ar_s = ar_snp_n; exp_ar_b = ar_byp_n;
`else
    exp_aw_s = 0; exp_aw_b = 0; exp_ar_s = 0; exp_ar_b = 0;
`endif
    check("perf_aw_snoop", 64'(a_aw_scnt), 64'(exp_aw_s));
    check("perf_aw_bypass", 64'(a_aw_bcnt), 64'(exp_aw_b));
    check("perf_ar_snoop", 64'(a_ar_scnt), 64'(exp_ar_s));
    check("perf_ar_bypass", 64'(a_ar_bcnt), 64'(exp_ar_b));

    // Forced decode modes on dut_b
    b_aw_chan_i = mk_aw(32'h4000, 3'b001, 2'b00, 2'b01);
    b_ar_chan_i = mk_ar(32'h4001, 4'b0000, 2'b00, 2'b00);
    b_aw_valid_i = 1'b1;
    b_ar_valid_i = 1'b1;
    @(posedge clk); #1;
    b_aw_valid_i = 1'b0;
    b_ar_valid_i = 1'b0;
    @(negedge clk);
    check("allbyp_aw_valid", 64'(b_aw_valid_o), 64'd1);
    check("allbyp_aw_snoop", 64'(b_aw_snoop_o), 64'd0);
    check("allsnp_ar_valid", 64'(b_ar_valid_o), 64'd1);
    check("allsnp_ar_snoop", 64'(b_ar_snoop_o), 64'd1);
    @(posedge clk); #1;
    b_done = 1'b0;

    // Reset with two AR entries buffered and one snoop outstanding
    send_ar(mk_ar(32'h5000, 4'b0001, 2'b00, 2'b00));
    @(posedge clk); #1;
    a_ar_ready_i = 1'b0;
    send_ar(mk_ar(32'h5001, 4'b0000, 2'b00, 2'b00));
    send_ar(mk_ar(32'h5002, 4'b0000, 2'b00, 2'b11));
    check("pre_rst_full", 64'(a_ar_ready_o), 64'd0);
    check("pre_rst_cnt", 64'(dut_a.u_ar.cnt_q), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 64'(a_ar_valid_o), 64'd0);
    check("mid_rst_ready", 64'(a_ar_ready_o), 64'd1);
    check("mid_rst_snoop", 64'(a_ar_snoop_o), 64'd0);
    check("mid_rst_cnt", 64'(dut_a.u_ar.cnt_q), 64'd0);
    check("mid_rst_perf_as", 64'(a_ar_scnt), 64'd0);
    check("mid_rst_perf_ab", 64'(a_ar_bcnt), 64'd0);
    check("mid_rst_perf_ws", 64'(a_aw_scnt), 64'd0);
    check("mid_rst_perf_wb", 64'(a_aw_bcnt), 64'd0);
    @(posedge clk); #1;
    a_ar_ready_i = 1'b1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
